load_store_unit: RTL and testbench

- Multi-cycle data-memory stage directly downstream of decode.
- Consumes the decoded LOAD/STORE opcode class and the funct3_t width code (BYTE, HALF, WORD, BYTE_U, HALF_U).
- Computes the effective address, runs a request/response handshake with data memory, and generates byte enables and store-data lanes.
- Returns sign- or zero-extended load data for the regfile FROM_MEM path and owns the memory-mapped output port at OUTPORT_ADDR.

---
 rtl/load_store_unit_pkg.sv | 40 ++++
 rtl/load_store_unit_extend.sv | 28 ++
 rtl/load_store_unit.sv | 186 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared width codes, FSM state type and store-lane helpers for the load/store unit.
package LOAD_STORE_FNS;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] OUTPORT_ADDR = 32'hfffc;

   typedef enum logic [2:0] {
      BYTE   = 3'b000,
      HALF   = 3'b001,
      WORD   = 3'b010,
      BYTE_U = 3'b100,
      HALF_U = 3'b101
   } funct3_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } lsu_state_t;

   // Byte enables for an access of the given size (funct3[1:0]) at byte offset off.
   function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b00:   return 4'b0001 << off;
         2'b01:   return off[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Replicate store data across all lanes so the byte enables pick the right one.
   function automatic logic [XLEN-1:0] store_lanes(input logic [1:0] size, input logic [XLEN-1:0] data);
      case (size)
         2'b00:   return {4{data[7:0]}};
         2'b01:   return {2{data[15:0]}};
         default: return data;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_extend.sv
// Extracts the addressed byte/half/word from a 32-bit word and sign/zero extends it.
module load_extend
   import LOAD_STORE_FNS::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [31:0] w_shifted;
   logic [15:0] w_half;

   assign w_shifted = word >> {offset, 3'b000};
   assign w_half    = offset[1] ? word[31:16] : word[15:0];

   always_comb begin
      result = word;
      case (funct3)
         BYTE:    result = {{24{w_shifted[7]}}, w_shifted[7:0]};
         BYTE_U:  result = {24'h0, w_shifted[7:0]};
         HALF:    result = {{16{w_half[15]}}, w_half};
         HALF_U:  result = {16'h0, w_half};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: effective address, memory request/response handshake,
// byte-lane store formatting, load extension and the memory-mapped output port.
module load_store_unit
   import LOAD_STORE_FNS::*;
#(
   parameter logic [31:0] OUTPORT_ADDR  = LOAD_STORE_FNS::OUTPORT_ADDR,
   parameter logic [31:0] OUTPORT_RESET = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] rs1_val,
   input  logic [31:0] imm,
   input  logic [31:0] rs2_val,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] load_data,
   output logic        fault,
   output logic [31:0] outport
);

   lsu_state_t  r_state;
   logic        r_mem_req;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [3:0]  r_mem_be;
   logic [31:0] r_mem_wdata;
   logic        r_busy;
   logic        r_done;
   logic [31:0] r_load_data;
   logic        r_fault;
   logic [31:0] r_outport;
   logic [1:0]  r_offset;
   logic [2:0]  r_funct3;
   logic        r_is_load;

   logic [31:0] w_ea;
   logic        w_f3_ok;
   logic        w_illegal;
   logic        w_misaligned;
   logic        w_is_out;
   logic [3:0]  w_be;
   logic [31:0] w_lanes;
   logic [31:0] w_out_merged;
   logic [31:0] w_ext_word;
   logic [1:0]  w_ext_off;
   logic [2:0]  w_ext_f3;
   logic [31:0] w_ext;

   assign w_ea = rs1_val + imm;

   always_comb begin
      w_f3_ok = 1'b0;
      if (is_load)
         w_f3_ok = funct3 inside {BYTE, HALF, WORD, BYTE_U, HALF_U};
      else if (is_store)
         w_f3_ok = funct3 inside {BYTE, HALF, WORD};
   end

   assign w_illegal    = (is_load == is_store) || !w_f3_ok;
   assign w_misaligned = ((funct3[1:0] == 2'b01) && w_ea[0]) ||
                         ((funct3[1:0] == 2'b10) && (w_ea[1:0] != 2'b00));
   assign w_is_out     = (w_ea[31:2] == OUTPORT_ADDR[31:2]);
   assign w_be         = store_be(funct3[1:0], w_ea[1:0]);
   assign w_lanes      = store_lanes(funct3[1:0], rs2_val);

   always_comb begin
      w_out_merged = r_outport;
      for (int i = 0; i < 4; i++) begin
         if (w_be[i])
            w_out_merged[8*i +: 8] = w_lanes[8*i +: 8];
      end
   end

   // Outport loads resolve straight from IDLE; memory loads resolve in WAIT from latched fields.
   assign w_ext_word = (r_state == IDLE) ? r_outport  : mem_rdata;
   assign w_ext_off  = (r_state == IDLE) ? w_ea[1:0]  : r_offset;
   assign w_ext_f3   = (r_state == IDLE) ? funct3     : r_funct3;

   load_extend u_load_extend (
      .word   (w_ext_word),
      .offset (w_ext_off),
      .funct3 (w_ext_f3),
      .result (w_ext)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 32'h0;
         r_mem_be    <= 4'h0;
         r_mem_wdata <= 32'h0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_load_data <= 32'h0;
         r_fault     <= 1'b0;
         r_outport   <= OUTPORT_RESET;
         r_offset    <= 2'b00;
         r_funct3    <= 3'b000;
         r_is_load   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_offset  <= w_ea[1:0];
                  r_funct3  <= funct3;
                  r_is_load <= is_load;
                  r_busy    <= 1'b1;
                  if (w_illegal || w_misaligned) begin
                     r_state <= RESP;
                     r_done  <= 1'b1;
                     r_fault <= 1'b1;
                  end else if (w_is_out) begin
                     r_state <= RESP;
                     r_done  <= 1'b1;
                     r_fault <= 1'b0;
                     if (is_store)
                        r_outport <= w_out_merged;
                     else
                        r_load_data <= w_ext;
                  end else begin
                     r_state     <= REQ;
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= is_store;
                     r_mem_addr  <= {w_ea[31:2], 2'b00};
                     r_mem_be    <= w_be;
                     r_mem_wdata <= w_lanes;
                  end
               end
            end
            REQ: begin
               if (mem_ready) begin
                  r_mem_req <= 1'b0;
                  if (r_is_load) begin
                     r_state <= WAIT;
                  end else begin
                     r_state <= RESP;
                     r_done  <= 1'b1;
                     r_fault <= 1'b0;
                  end
               end
            end
            WAIT: begin
               if (mem_rvalid) begin
                  r_load_data <= w_ext;
                  r_state     <= RESP;
                  r_done      <= 1'b1;
                  r_fault     <= 1'b0;
               end
            end
            RESP: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_fault <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_be    = r_mem_be;
   assign mem_wdata = r_mem_wdata;
   assign busy      = r_busy;
   assign done      = r_done;
   assign load_data = r_load_data;
   assign fault     = r_fault;
   assign outport   = r_outport;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: memory stores/loads, stalls, faults, outport and reset.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        is_load;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] rs1_val;
   logic [31:0] imm;
   logic [31:0] rs2_val;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        done;
   logic [31:0] load_data;
   logic        fault;
   logic [31:0] outport;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .is_load    (is_load),
      .is_store   (is_store),
      .funct3     (funct3),
      .rs1_val    (rs1_val),
      .imm        (imm),
      .rs2_val    (rs2_val),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_ready  (mem_ready),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .busy       (busy),
      .done       (done),
      .load_data  (load_data),
      .fault      (fault),
      .outport    (outport)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a request for one cycle; returns just after the sampling edge.
   task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] base, input logic [31:0] off, input logic [31:0] data);
      start    = 1'b1;
      is_load  = ld;
      is_store = st;
      funct3   = f3;
      rs1_val  = base;
      imm      = off;
      rs2_val  = data;
      step();
      start    = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      is_load    = 1'b0;
      is_store   = 1'b0;
      funct3     = 3'b000;
      rs1_val    = 32'h0;
      imm        = 32'h0;
      rs2_val    = 32'h0;
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      step();
      step();
      rst = 1'b0;
      step();

      chk("rst_mem_req",   32'(mem_req),   32'h0);
      chk("rst_mem_addr",  mem_addr,       32'h0);
      chk("rst_mem_be",    32'(mem_be),    32'h0);
      chk("rst_busy",      32'(busy),      32'h0);
      chk("rst_done",      32'(done),      32'h0);
      chk("rst_load_data", load_data,      32'h0);
      chk("rst_fault",     32'(fault),     32'h0);
      chk("rst_outport",   outport,        32'h0);

      // Store WORD to 0x104 with memory always ready: start, REQ, RESP(done).
      mem_ready = 1'b1;
      issue(1'b0, 1'b1, 3'b010, 32'h100, 32'h4, 32'hDEADBEEF);
      chk("sw_req",   32'(mem_req),   32'h1);
      chk("sw_we",    32'(mem_we),    32'h1);
      chk("sw_addr",  mem_addr,       32'h104);
      chk("sw_be",    32'(mem_be),    32'hF);
      chk("sw_wdata", mem_wdata,      32'hDEADBEEF);
      chk("sw_busy",  32'(busy),      32'h1);
      chk("sw_nodone", 32'(done),     32'h0);
      step();
      chk("sw_done",  32'(done),      32'h1);
      chk("sw_fault", 32'(fault),     32'h0);
      chk("sw_reqlo", 32'(mem_req),   32'h0);
      step();
      chk("sw_idle_done", 32'(done),  32'h0);
      chk("sw_idle_busy", 32'(busy),  32'h0);

      // Load BYTE at 0x203, data two cycles after acceptance.
      issue(1'b1, 1'b0, 3'b000, 32'h200, 32'h3, 32'h0);
      chk("lb_req",  32'(mem_req), 32'h1);
      chk("lb_we",   32'(mem_we),  32'h0);
      chk("lb_addr", mem_addr,     32'h200);
      step();
      mem_ready = 1'b0;
      chk("lb_reqdrop", 32'(mem_req), 32'h0);
      step();
      chk("lb_wait_done", 32'(done), 32'h0);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h80FF0000;
      step();
      mem_rvalid = 1'b0;
      chk("lb_done", 32'(done), 32'h1);
      chk("lb_data", load_data, 32'hFFFFFF80);
      chk("lb_fault", 32'(fault), 32'h0);
      step();

      // Same access with BYTE_U.
      mem_ready = 1'b1;
      issue(1'b1, 1'b0, 3'b100, 32'h200, 32'h3, 32'h0);
      step();
      mem_ready = 1'b0;
      step();
      mem_rvalid = 1'b1;
      step();
      mem_rvalid = 1'b0;
      chk("lbu_done", 32'(done), 32'h1);
      chk("lbu_data", load_data, 32'h00000080);
      step();

      // Store HALF at 0x12 with mem_ready low for three cycles.
      issue(1'b0, 1'b1, 3'b001, 32'h10, 32'h2, 32'h0000ABCD);
      for (int i = 0; i < 3; i++) begin
         chk("sh_req",   32'(mem_req), 32'h1);
         chk("sh_addr",  mem_addr,     32'h10);
         chk("sh_be",    32'(mem_be),  32'hC);
         chk("sh_wdata", mem_wdata,    32'hABCDABCD);
         chk("sh_nodone", 32'(done),   32'h0);
         step();
      end
      mem_ready = 1'b1;
      chk("sh_req_last", 32'(mem_req), 32'h1);
      step();
      mem_ready = 1'b0;
      chk("sh_done",  32'(done),    32'h1);
      chk("sh_reqlo", 32'(mem_req), 32'h0);
      step();
      chk("sh_single", 32'(mem_req), 32'h0);

      // Misaligned WORD load at 0x6 faults without touching memory.
      issue(1'b1, 1'b0, 3'b010, 32'h4, 32'h2, 32'h0);
      chk("mis_req",   32'(mem_req), 32'h0);
      chk("mis_done",  32'(done),    32'h1);
      chk("mis_fault", 32'(fault),   32'h1);
      chk("mis_ld",    load_data,    32'h00000080);
      step();
      chk("mis_after", 32'(done),    32'h0);

      // Illegal load funct3=011.
      issue(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0);
      chk("ill_req",   32'(mem_req), 32'h0);
      chk("ill_done",  32'(done),    32'h1);
      chk("ill_fault", 32'(fault),   32'h1);
      step();

      // Illegal: neither load nor store.
      issue(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0);
      chk("none_fault", 32'(fault),  32'h1);
      chk("none_req",   32'(mem_req), 32'h0);
      step();

      // Effective address wraps modulo 2^32.
      mem_ready = 1'b1;
      issue(1'b0, 1'b1, 3'b010, 32'hFFFFFFFC, 32'h8, 32'h12345678);
      chk("wrap_addr", mem_addr, 32'h4);
      step();
      chk("wrap_done", 32'(done), 32'h1);
      step();
      mem_ready = 1'b0;

      // Outport byte store at 0xfffd and word readback.
      issue(1'b0, 1'b1, 3'b000, 32'hFFF0, 32'hD, 32'h5A);
      chk("op_st_req",  32'(mem_req), 32'h0);
      chk("op_st_done", 32'(done),    32'h1);
      chk("op_st_val",  outport,      32'h00005A00);
      step();
      issue(1'b1, 1'b0, 3'b010, 32'hFFFC, 32'h0, 32'h0);
      chk("op_ld_req",  32'(mem_req), 32'h0);
      chk("op_ld_done", 32'(done),    32'h1);
      chk("op_ld_val",  load_data,    32'h00005A00);
      step();
      issue(1'b1, 1'b0, 3'b000, 32'hFFFC, 32'h1, 32'h0);
      chk("op_lb_val",  load_data,    32'h0000005A);
      step();

      // Reset while in WAIT, then a stale mem_rvalid.
      mem_ready = 1'b1;
      issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0);
      step();
      mem_ready = 1'b0;
      chk("rw_busy_wait", 32'(busy), 32'h1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hCAFEF00D;
      chk("rw_busy", 32'(busy),    32'h0);
      chk("rw_req",  32'(mem_req), 32'h0);
      chk("rw_out",  outport,      32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rw_nodone", 32'(done), 32'h0);
         chk("rw_idle",   32'(busy), 32'h0);
      end
      mem_rvalid = 1'b0;
      chk("rw_ld", load_data, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
